fx2_stream_writer: RTL and testbench
====================================

# fx2_stream_writer

Parametrised multi-channel writer into the Cypress FX2 slave FIFO. It accepts WORD_W-bit words from NCH valid/ready sources through a round-robin arbiter and buffers them in an internal FIFO. Each word is serialised into 16-bit beats, least-significant beat first, on the FX2 data bus, gated by the FX2 full flag. A beat counter drives PKTEND for short-packet commits. It sits between the processing pipelines and the FX2 pins on the ifclk domain and replaces the fixed 32-bit, single-source writer.

## Interface
- WORD_W, 32: input word width; multiple of 16, range 16..128; BEATS = WORD_W/16.
- NCH, 2: number of source channels, 1..8.
- FIFO_DEPTH, 16: word buffer depth; power of 2, ≥2.
- PKT_LEN, 256: beats per USB packet (FX2 auto-commit size); 0 disables packet tracking and flush.
- clk  in  1: FX2 ifclk; all logic on rising edge.
- reset  in  1: synchronous, active-high.
- s_valid  in  NCH: per-channel word valid.
- s_data  in  NCH*WORD_W: channel i occupies bits [i*WORD_W +: WORD_W].
- s_ready  out  NCH: per-channel accept; a transfer happens when s_valid[i] and s_ready[i] are both high.
- flush  in  1: one-cycle request to commit a partial packet.
- flag_nf  in  1: FX2 FLAGA, high = not full; synchronous to clk.
- fd  out  16: FX2 data bus.
- slwr_n  out  1: FX2 write strobe, active-low, registered.
- pktend_n  out  1: FX2 packet end, active-low, registered.
- cur_ch  out  clog2(NCH) (min 1): channel of the word currently being serialised.
- busy  out  1: high when the FIFO is non-empty, the serialiser is active, or a flush is pending.

## Operation
- Arbiter:
  - Grant goes to the first channel with s_valid high, searching from rr_ptr upward with wrap.
  - s_ready[i] = (i == grant) & !fifo_full & !reset; this is combinational and at most one bit is high.
  - After each transfer, rr_ptr = grant+1 mod NCH. rr_ptr resets to 0.
- FIFO stores {channel id, word}. There is no push when full, even if a pop happens in the same cycle. Pop and push may coincide when the FIFO is not full.
- Serialiser states:
  - IDLE: if the FIFO is non-empty, pop into the shift register, set cur_ch, beat=0, go to SEND. Otherwise, if flush is pending, go to FLUSH.
  - SEND:
    - If flag_nf is high: drive fd=shift[16*beat +: 16] and slwr_n=0 next cycle, then beat++.
    - If flag_nf is low: slwr_n=1 next cycle, and fd and beat hold.
    - After beat BEATS-1 is written: if the FIFO is non-empty, pop the next word immediately with no idle cycle. Otherwise go to IDLE.
  - FLUSH:
    - If pkt_cnt != 0: drive pktend_n=0 for exactly one cycle with slwr_n=1, clear pkt_cnt, clear the pending flag, go to IDLE.
    - If pkt_cnt == 0: clear the pending flag without any strobe (no zero-length packets).
- pkt_cnt counts written beats (slwr_n=0 cycles) modulo PKT_LEN and wraps to 0 silently at PKT_LEN, because the FX2 auto-commits.
- A flush pulse sets the pending flag. It is serviced only once the FIFO is empty and the serialiser is in IDLE, so all earlier data precedes PKTEND. Words arriving while the flag is pending are still accepted; they delay the flush and are included in the packet it commits. Repeated flush pulses while pending are merged.
- PKT_LEN=0: flush is ignored, pktend_n stays at 1, pkt_cnt is unused.
- The FX2 programmable flag is configured with ≥2 words of margin, so one beat written after FLAGA falls is tolerated.

## Timing
- Reset values:
  - Outputs: fd=0, slwr_n=1, pktend_n=1, s_ready=0, cur_ch=0, busy=0.
  - Internal: FIFO empty, pkt_cnt=0, flush pending=0, state IDLE.
- Latency: a word accepted in cycle t is popped at t+1 and its first slwr_n=0 appears at t+2, provided flag_nf is high at t+1.
- Throughput: one beat per cycle, i.e. a sustained 1 word per BEATS cycles with flag_nf high.
- flag_nf is sampled in cycle t and controls slwr_n in cycle t+1.
- fd changes only together with a slwr_n=0 cycle; it holds its last value otherwise.
- Reset mid-word: the partial word and FIFO contents are discarded, no pktend is issued, and the outputs return to their reset values on the next edge.

## Test plan
- WORD_W=32, NCH=1, word 0xAAAA5555, flag_nf=1 -> slwr_n low for 2 consecutive cycles, fd=0x5555 then 0xAAAA, first strobe 2 cycles after acceptance.
- flag_nf low for 3 cycles between beats 0 and 1 -> slwr_n=1 for those 3 cycles, fd holds 0x5555, beat 1 resumes one cycle after flag_nf rises; no beat lost or duplicated.
- NCH=3, all valid continuously, FIFO_DEPTH=4, WORD_W=16 -> acceptance order 0,1,2,0,1,2…; s_ready all 0 while the FIFO is full; cur_ch matches the data origin.
- PKT_LEN=4, 3 beats then flush -> one pktend_n=0 cycle after the third strobe, with slwr_n=1. A second flush with pkt_cnt=0 -> no pktend.
- PKT_LEN=4, 4 beats then flush -> pkt_cnt wrapped to 0, no pktend; a 5th beat followed by flush -> pktend.
- Reset asserted after beat 0 of a 64-bit word with 3 words queued -> slwr_n=1 and busy=0 after the edge; post-reset traffic starts from a fresh word with pkt_cnt=0.

Source files
------------

// File: rtl/fx2_stream_writer.sv
// fx2_stream_writer
//   Multi-channel writer into the Cypress FX2 slave FIFO. NCH valid/ready
//   sources are arbitrated round-robin into a word FIFO that stores
//   {channel id, word}. Each word is sent as 16-bit beats on the FX2 data bus,
//   least-significant beat first, one beat per cycle while FLAGA (not full) is
//   high. A beat counter tracks the position inside the current USB packet so
//   that a flush request can commit a short packet with PKTEND.
//
// Parameters
//   WORD_W     : source word width, multiple of 16 (16..128)
//   NCH        : number of source channels (1..8)
//   FIFO_DEPTH : word buffer depth, power of 2, >= 2
//   PKT_LEN    : beats per USB packet; 0 disables packet tracking and flush
//
// Ports
//   clk       in   FX2 ifclk, all logic on the rising edge
//   reset     in   synchronous, active-high
//   s_valid   in   [NCH]        per-channel word valid
//   s_data    in   [NCH*WORD_W] channel i at [i*WORD_W +: WORD_W]
//   s_ready   out  [NCH]        per-channel accept (at most one bit high)
//   flush     in   one-cycle request to commit a partial packet
//   flag_nf   in   FX2 FLAGA, high = not full
//   fd        out  [16]         FX2 data bus
//   slwr_n    out  FX2 write strobe, active-low, registered
//   pktend_n  out  FX2 packet end, active-low, registered
//   cur_ch    out  [CH_W]       channel of the word being serialised
//   busy      out  FIFO non-empty, serialiser active or flush pending
module fx2_stream_writer #(
  parameter  int WORD_W     = 32,
  parameter  int NCH        = 2,
  parameter  int FIFO_DEPTH = 16,
  parameter  int PKT_LEN    = 256,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        s_valid,
  input  logic [NCH*WORD_W-1:0] s_data,
  output logic [NCH-1:0]        s_ready,
  input  logic                  flush,
  input  logic                  flag_nf,
  output logic [15:0]           fd,
  output logic                  slwr_n,
  output logic                  pktend_n,
  output logic [CH_W-1:0]       cur_ch,
  output logic                  busy
);

  localparam int BEATS  = WORD_W / 16;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int ENT_W  = CH_W + WORD_W;
  localparam int PC_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_AFTER = BEAT_W'((BEATS > 1) ? 1 : 0);
  localparam logic [PC_W-1:0]   PKT_LAST   = PC_W'((PKT_LEN > 0) ? PKT_LEN - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_FLUSH
  } state_t;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant;
  logic              found;
  logic [WORD_W-1:0] in_word;
  logic              push;
  logic              fifo_full;

  // Search rr_ptr..NCH-1 first, then wrap to 0..rr_ptr-1.
  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a value unassigned (no latch).
  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && s_valid[i] && (CH_W'(i) >= rr_ptr)) begin
        grant = CH_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!found && s_valid[i] && (CH_W'(i) < rr_ptr)) begin
        grant = CH_W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    s_ready = '0;
    if (!reset && !fifo_full) s_ready[grant] = 1'b1;
  end

  always_comb begin
    in_word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == CH_W'(i)) in_word = s_data[i*WORD_W +: WORD_W];
    end
  end

  assign push = |(s_valid & s_ready);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (grant == CH_W'(NCH - 1)) ? '0 : grant + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Word FIFO of {channel id, word}
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              fifo_empty;
  logic              pop;
  logic [ENT_W-1:0]  head;
  logic [CH_W-1:0]   head_ch;
  logic [WORD_W-1:0] head_word;

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign head_ch    = head[ENT_W-1 -: CH_W];
  assign head_word  = head[WORD_W-1:0];

  // NOTE: the storage array has no reset; validity is carried entirely by the
  // pointers and count, which keeps the array mappable onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {grant, in_word};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser and packet tracking
  // ---------------------------------------------------------------------------
  state_t            state;
  logic [WORD_W-1:0] shift;
  logic [BEAT_W-1:0] beat;
  logic [PC_W-1:0]   pkt_cnt;
  logic              flush_pend;
  logic              write_beat;

  // A word is popped in IDLE; if FLAGA allows, its first beat goes out in the
  // same cycle, so back-to-back words stream with no gap between them.
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign write_beat = flag_nf && (pop || (state == ST_SEND));
  assign busy       = !fifo_empty || (state != ST_IDLE) || flush_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shift      <= '0;
      beat       <= '0;
      cur_ch     <= '0;
      fd         <= '0;
      slwr_n     <= 1'b1;
      pktend_n   <= 1'b1;
      pkt_cnt    <= '0;
      flush_pend <= 1'b0;
    end else begin
      slwr_n   <= 1'b1;
      pktend_n <= 1'b1;

      if (flush && (PKT_LEN != 0)) flush_pend <= 1'b1;

      // The FX2 auto-commits full packets, so the count wraps silently.
      if (write_beat && (PKT_LEN != 0)) begin
        pkt_cnt <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_ch <= head_ch;
            if (flag_nf) begin
              fd     <= head_word[15:0];
              slwr_n <= 1'b0;
              shift  <= head_word >> 16;
              beat   <= BEAT_AFTER;
              state  <= (BEATS > 1) ? ST_SEND : ST_IDLE;
            end else begin
              shift <= head_word;
              beat  <= '0;
              state <= ST_SEND;
            end
          end else if (flush_pend) begin
            state <= ST_FLUSH;
          end
        end

        ST_SEND: begin
          if (flag_nf) begin
            fd     <= shift[15:0];
            slwr_n <= 1'b0;
            shift  <= shift >> 16;
            if (beat == BEAT_LAST) begin
              beat  <= '0;
              state <= ST_IDLE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end

        ST_FLUSH: begin
          // Only a non-empty partial packet is committed; no zero-length packets.
          if ((PKT_LEN != 0) && (pkt_cnt != '0)) begin
            pktend_n <= 1'b0;
            pkt_cnt  <= '0;
          end
          flush_pend <= 1'b0;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_stream_writer.sv
// Testbench for fx2_stream_writer with WORD_W=32, NCH=3, FIFO_DEPTH=4,
// PKT_LEN=4. Inputs are driven and outputs sampled on the falling edge.
module tb_fx2_stream_writer;

  localparam int WORD_W     = 32;
  localparam int NCH        = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int PKT_LEN    = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NCH-1:0]        s_valid = '0;
  logic [NCH*WORD_W-1:0] s_data = '0;
  logic [NCH-1:0]        s_ready;
  logic                  flush = 1'b0;
  logic                  flag_nf = 1'b0;
  logic [15:0]           fd;
  logic                  slwr_n;
  logic                  pktend_n;
  logic [1:0]            cur_ch;
  logic                  busy;

  int checks = 0;
  int failures = 0;

  logic [15:0] obs_fd[$];
  logic [1:0]  obs_ch[$];

  fx2_stream_writer #(
    .WORD_W    (WORD_W),
    .NCH       (NCH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PKT_LEN   (PKT_LEN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .flush   (flush),
    .flag_nf (flag_nf),
    .fd      (fd),
    .slwr_n  (slwr_n),
    .pktend_n(pktend_n),
    .cur_ch  (cur_ch),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Offers one word on a channel until accepted; returns on the falling edge
  // after the accepting clock edge with the channel's valid dropped.
  task automatic push_word(input int ch, input logic [31:0] d);
    int n;
    n = 0;
    s_data[ch*WORD_W +: WORD_W] = d;
    s_valid[ch] = 1'b1;
    #1;
    while (!s_ready[ch] && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (s_ready[ch] !== 1'b1) begin
      failures++;
      $display("FAIL push_accept: ch %0d s_ready=%b required 1 within 40 cycles", ch, s_ready[ch]);
    end
    @(negedge clk);
    s_valid[ch] = 1'b0;
  endtask

  // Watches n falling edges, optionally pulsing flush on the first cycle.
  task automatic observe(input int n, input bit pulse,
                         output int strobes, output int ends, output int overlap,
                         output int end_first_idx, output int last_strobe_idx);
    strobes = 0;
    ends = 0;
    overlap = 0;
    end_first_idx = -1;
    last_strobe_idx = -1;
    obs_fd.delete();
    obs_ch.delete();
    if (pulse) flush = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (slwr_n === 1'b0) begin
        strobes++;
        last_strobe_idx = i;
        obs_fd.push_back(fd);
        obs_ch.push_back(cur_ch);
      end
      if (pktend_n === 1'b0) begin
        ends++;
        if (end_first_idx < 0) end_first_idx = i;
        if (slwr_n !== 1'b1) overlap++;
      end
      @(negedge clk);
      flush = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_valid = '1;
    flag_nf = 1'b1;
    step();
    step();
    #1;
    checks++; if (s_ready !== 3'b000) begin failures++; $display("FAIL reset_s_ready: got %b required 000", s_ready); end
    checks++; if (slwr_n !== 1'b1) begin failures++; $display("FAIL reset_slwr_n: got %b required 1", slwr_n); end
    checks++; if (pktend_n !== 1'b1) begin failures++; $display("FAIL reset_pktend_n: got %b required 1", pktend_n); end
    checks++; if (fd !== 16'h0000) begin failures++; $display("FAIL reset_fd: got %h required 0000", fd); end
    checks++; if (cur_ch !== 2'd0) begin failures++; $display("FAIL reset_cur_ch: got %0d required 0", cur_ch); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    s_valid = '0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_word();
    flag_nf = 1'b1;
    s_data[31:0] = 32'hAAAA_5555;
    s_valid = 3'b001;
    #1;
    checks++; if (s_ready !== 3'b001) begin failures++; $display("FAIL single_s_ready: got %b required 001", s_ready); end
    step();
    s_valid = '0;
    checks++; if (slwr_n !== 1'b1) begin failures++; $display("FAIL single_pop_cycle_slwr: got %b required 1", slwr_n); end
    step();
    checks++; if (slwr_n !== 1'b0) begin failures++; $display("FAIL single_beat0_slwr: got %b required 0", slwr_n); end
    checks++; if (fd !== 16'h5555) begin failures++; $display("FAIL single_beat0_fd: got %h required 5555", fd); end
    checks++; if (cur_ch !== 2'd0) begin failures++; $display("FAIL single_cur_ch: got %0d required 0", cur_ch); end
    step();
    checks++; if (slwr_n !== 1'b0) begin failures++; $display("FAIL single_beat1_slwr: got %b required 0", slwr_n); end
    checks++; if (fd !== 16'hAAAA) begin failures++; $display("FAIL single_beat1_fd: got %h required AAAA", fd); end
    step();
    checks++; if (slwr_n !== 1'b1) begin failures++; $display("FAIL single_end_slwr: got %b required 1", slwr_n); end
    checks++; if (fd !== 16'hAAAA) begin failures++; $display("FAIL single_fd_hold: got %h required AAAA", fd); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b required 0", busy); end
  endtask

  task automatic test_flag_stall();
    flag_nf = 1'b1;
    push_word(0, 32'h1234_5678);
    step();
    checks++; if (slwr_n !== 1'b0) begin failures++; $display("FAIL stall_beat0_slwr: got %b required 0", slwr_n); end
    checks++; if (fd !== 16'h5678) begin failures++; $display("FAIL stall_beat0_fd: got %h required 5678", fd); end
    flag_nf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (slwr_n !== 1'b1) begin failures++; $display("FAIL stall_hold_slwr[%0d]: got %b required 1", i, slwr_n); end
      checks++; if (fd !== 16'h5678) begin failures++; $display("FAIL stall_hold_fd[%0d]: got %h required 5678", i, fd); end
    end
    flag_nf = 1'b1;
    step();
    checks++; if (slwr_n !== 1'b0) begin failures++; $display("FAIL stall_beat1_slwr: got %b required 0", slwr_n); end
    checks++; if (fd !== 16'h1234) begin failures++; $display("FAIL stall_beat1_fd: got %h required 1234", fd); end
    step();
    checks++; if (slwr_n !== 1'b1) begin failures++; $display("FAIL stall_no_extra_beat: got %b required 1", slwr_n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_busy: got %b required 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 0, 1};
    int ch;
    logic [15:0] exp_fd;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    flag_nf = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      s_data[i*WORD_W +: WORD_W] = {16'(16'hB000 + i), 16'(16'hA000 + i)};
    end
    s_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (s_ready !== (3'b001 << exp_order[k])) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got %b required %b", k, s_ready, 3'b001 << exp_order[k]);
      end
      step();
    end
    #1;
    checks++; if (s_ready !== 3'b000) begin failures++; $display("FAIL rr_full_ready: got %b required 000", s_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rr_full_busy: got %b required 1", busy); end
    step();
    #1;
    checks++; if (s_ready !== 3'b000) begin failures++; $display("FAIL rr_full_ready_hold: got %b required 000", s_ready); end
    s_valid = '0;
    flag_nf = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      ch = exp_order[k / 2];
      exp_fd = (k % 2 == 1) ? 16'(16'hB000 + ch) : 16'(16'hA000 + ch);
      checks++; if (slwr_n !== 1'b0) begin failures++; $display("FAIL rr_stream_slwr[%0d]: got %b required 0", k, slwr_n); end
      checks++; if (fd !== exp_fd) begin failures++; $display("FAIL rr_stream_fd[%0d]: got %h required %h", k, fd, exp_fd); end
      checks++; if (cur_ch !== 2'(ch)) begin failures++; $display("FAIL rr_stream_cur_ch[%0d]: got %0d required %0d", k, cur_ch, ch); end
      step();
    end
    checks++; if (slwr_n !== 1'b1) begin failures++; $display("FAIL rr_stream_end_slwr: got %b required 1", slwr_n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_stream_end_busy: got %b required 0", busy); end
  endtask

  // Packet count is 2 on entry (10 beats since the last reset).
  task automatic test_flush();
    int strobes, ends, overlap, end_idx, last_idx;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_pending_busy: got %b required 1", busy); end
    observe(8, 1'b0, strobes, ends, overlap, end_idx, last_idx);
    checks++; if (ends !== 1) begin failures++; $display("FAIL flush_partial_pktend_cycles: got %0d required 1", ends); end
    checks++; if (overlap !== 0) begin failures++; $display("FAIL flush_partial_overlap: got %0d required 0", overlap); end
    checks++; if (strobes !== 0) begin failures++; $display("FAIL flush_partial_strobes: got %0d required 0", strobes); end
    observe(8, 1'b1, strobes, ends, overlap, end_idx, last_idx);
    checks++; if (ends !== 0) begin failures++; $display("FAIL flush_empty_pktend_cycles: got %0d required 0", ends); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_empty_busy: got %b required 0", busy); end
  endtask

  task automatic test_packet_wrap();
    int strobes, ends, overlap, end_idx, last_idx;
    logic [15:0] exp4 [4] = '{16'h0001, 16'hCAFE, 16'h0002, 16'hCAFE};
    flag_nf = 1'b1;
    push_word(0, 32'hCAFE_0001);
    push_word(0, 32'hCAFE_0002);
    observe(12, 1'b1, strobes, ends, overlap, end_idx, last_idx);
    checks++; if (strobes !== 4) begin failures++; $display("FAIL wrap_strobes: got %0d required 4", strobes); end
    checks++; if (ends !== 0) begin failures++; $display("FAIL wrap_pktend_cycles: got %0d required 0", ends); end
    if (obs_fd.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (obs_fd[i] !== exp4[i]) begin failures++; $display("FAIL wrap_fd[%0d]: got %h required %h", i, obs_fd[i], exp4[i]); end
      end
    end
    push_word(0, 32'hBEEF_0003);
    observe(10, 1'b1, strobes, ends, overlap, end_idx, last_idx);
    checks++; if (strobes !== 2) begin failures++; $display("FAIL wrap_fifth_strobes: got %0d required 2", strobes); end
    checks++; if (ends !== 1) begin failures++; $display("FAIL wrap_fifth_pktend_cycles: got %0d required 1", ends); end
    checks++; if (overlap !== 0) begin failures++; $display("FAIL wrap_fifth_overlap: got %0d required 0", overlap); end
    checks++; if (end_idx <= last_idx) begin failures++; $display("FAIL wrap_fifth_order: pktend at %0d required after last strobe at %0d", end_idx, last_idx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_busy: got %b required 0", busy); end
  endtask

  task automatic test_reset_mid_word();
    int strobes, ends, overlap, end_idx, last_idx;
    logic [15:0] exp4 [4] = '{16'h4444, 16'h3333, 16'h6666, 16'h5555};
    flag_nf = 1'b0;
    push_word(0, 32'h0BAD_F00D);
    push_word(0, 32'h1111_2222);
    push_word(0, 32'h7777_8888);
    push_word(0, 32'h9999_AAAA);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_queued_busy: got %b required 1", busy); end
    flag_nf = 1'b1;
    step();
    checks++; if (slwr_n !== 1'b0) begin failures++; $display("FAIL midrst_beat0_slwr: got %b required 0", slwr_n); end
    checks++; if (fd !== 16'hF00D) begin failures++; $display("FAIL midrst_beat0_fd: got %h required F00D", fd); end
    flag_nf = 1'b0;
    reset = 1'b1;
    step();
    checks++; if (slwr_n !== 1'b1) begin failures++; $display("FAIL midrst_slwr: got %b required 1", slwr_n); end
    checks++; if (pktend_n !== 1'b1) begin failures++; $display("FAIL midrst_pktend: got %b required 1", pktend_n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++; if (fd !== 16'h0000) begin failures++; $display("FAIL midrst_fd: got %h required 0000", fd); end
    checks++; if (s_ready !== 3'b000) begin failures++; $display("FAIL midrst_s_ready: got %b required 000", s_ready); end
    reset = 1'b0;
    flag_nf = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_fifo_cleared: got %b required 0", busy); end
    checks++; if (slwr_n !== 1'b1) begin failures++; $display("FAIL midrst_no_stale_beat: got %b required 1", slwr_n); end
    push_word(1, 32'h3333_4444);
    push_word(1, 32'h5555_6666);
    observe(12, 1'b1, strobes, ends, overlap, end_idx, last_idx);
    checks++; if (strobes !== 4) begin failures++; $display("FAIL midrst_post_strobes: got %0d required 4", strobes); end
    checks++; if (ends !== 0) begin failures++; $display("FAIL midrst_post_pktend_cycles: got %0d required 0", ends); end
    if (obs_fd.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (obs_fd[i] !== exp4[i]) begin failures++; $display("FAIL midrst_post_fd[%0d]: got %h required %h", i, obs_fd[i], exp4[i]); end
        checks++; if (obs_ch[i] !== 2'd1) begin failures++; $display("FAIL midrst_post_cur_ch[%0d]: got %0d required 1", i, obs_ch[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_flag_stall();
    test_round_robin();
    test_flush();
    test_packet_wrap();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
